// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC select and IF/ID pipeline register
// Hazard controls gate PC and IF/ID independently; saturating debug counters track stalls and flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_hold,
  input  logic             if_id_hold,
  input  logic             if_flush,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      imem_addr,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // A held PC drops any redirect; ID re-presents it on the next unheld cycle.
  always_comb begin
    pc_next = pc;
    if (pc_hold)           pc_next = pc;
    else if (jump)         pc_next = {jump_target[31:2], 2'b00};
    else if (branch_taken) pc_next = {branch_target[31:2], 2'b00};
    else if (imem_valid)   pc_next = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      pc <= pc_next;

      if (!if_id_hold) begin
        if (if_flush || !imem_valid) begin
          if_id_instr <= NOP_INSTR;
          if_id_pc4   <= 32'd0;
          if_id_valid <= 1'b0;
        end else begin
          if_id_instr <= imem_rdata;
          if_id_pc4   <= pc_plus4;
          if_id_valid <= 1'b1;
        end
      end

      if (pc_hold && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_flush && !if_id_hold && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed plus randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;

  localparam int          CNT_W = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0BAD_0000;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pc_hold, if_id_hold, if_flush, jump, branch_taken, imem_valid;
  logic [31:0]      jump_target, branch_target, imem_rdata;
  logic [31:0]      imem_addr, if_id_instr, if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_flush(if_flush),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .imem_addr(imem_addr), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int fail_cnt = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    imem_addr, m_pc);
    check({tag, ".instr"}, if_id_instr, m_instr);
    check({tag, ".pc4"},   if_id_pc4, m_pc4);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ".flush"}, 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the documented rules, check after the edge.
  task automatic step(input string tag, input logic h, input logic ih, input logic fl,
                      input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
                      input logic [31:0] rd, input logic v);
    logic [31:0] npc, seq;
    pc_hold = h; if_id_hold = ih; if_flush = fl; jump = j; jump_target = jt;
    branch_taken = b; branch_target = bt; imem_rdata = rd; imem_valid = v;
    seq = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    if (h)      npc = m_pc;
    else if (j) npc = jt - (jt % 4);
    else if (b) npc = bt - (bt % 4);
    else if (!v) npc = m_pc;
    else        npc = seq;
    if (!ih) begin
      if (fl || !v) begin m_instr = NOP; m_pc4 = 0; m_valid = 0; end
      else begin m_instr = rd; m_pc4 = seq; m_valid = 1; end
    end
    if (h && m_stall < CMAX) m_stall++;
    if (fl && !ih && m_flush < CMAX) m_flush++;
    m_pc = npc;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic seq_step(input string tag, input logic [31:0] rd);
    step(tag, 0, 0, 0, 0, 0, 0, 0, rd, 1);
  endtask

  task automatic goto(input string tag, input logic [31:0] a);
    step(tag, 0, 0, 1, 1, a, 0, 0, 32'h0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    {pc_hold, if_id_hold, if_flush, jump, branch_taken, imem_valid} = '0;
    jump_target = 0; branch_target = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    #1;

    // T1 startup: addresses 0,4,8 then 12 on consecutive edges
    check({"t1.addr0"}, imem_addr, 32'h0);
    seq_step("t1.a", 32'h1111_0000);
    check("t1.addr4", imem_addr, 32'h4);
    seq_step("t1.b", 32'h2222_0000);
    check("t1.addr8", imem_addr, 32'h8);
    seq_step("t1.c", 32'h3333_0000);

    // T2 sequential fetch at 0x10
    goto("t2.goto", 32'h10);
    seq_step("t2", 32'h8C08_0004);
    check("t2.instr", if_id_instr, 32'h8C08_0004);
    check("t2.pc4", if_id_pc4, 32'h14);
    check("t2.valid", 32'(if_id_valid), 32'h1);

    // T3 stall two cycles at 0x20
    goto("t3.goto", 32'h20);
    seq_step("t3.fill", 32'hABCD_1234);
    goto("t3.goto2", 32'h20);
    seq_step("t3.fill2", 32'h1357_2468);
    step("t3.h1", 1, 1, 0, 0, 0, 0, 0, 32'hFFFF_0000, 1);
    step("t3.h2", 1, 1, 0, 0, 0, 0, 0, 32'hEEEE_0000, 1);
    check("t3.pc", imem_addr, 32'h24);
    check("t3.stall", 32'(stall_cnt), 32'h2);

    // T4 jump with flush to unaligned target
    step("t4", 0, 0, 1, 1, 32'h103, 0, 0, 32'h5555_5555, 1);
    check("t4.pc", imem_addr, 32'h100);
    check("t4.instr", if_id_instr, NOP);

    // T5 conflicts
    step("t5.holdjump", 1, 0, 0, 1, 32'h400, 0, 0, 32'h6666_0000, 1);
    check("t5.holdpc", imem_addr, 32'h100);
    step("t5.jumpbr", 0, 0, 0, 1, 32'h200, 1, 32'h300, 32'h7777_0000, 1);
    check("t5.jumpwins", imem_addr, 32'h200);
    step("t5.branch", 0, 0, 0, 0, 0, 1, 32'h302, 32'h7777_1111, 1);
    step("t5.nomem", 0, 0, 0, 0, 0, 0, 0, 32'h8888_0000, 0);
    check("t5.bubble", 32'(if_id_valid), 32'h0);

    // Mid-run asynchronous reset from pc=0x40
    goto("rst.goto", 32'h40);
    seq_step("rst.fill", 32'h9999_0000);
    goto("rst.goto2", 32'h40);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst.async");
    @(negedge clk) rst_n = 1'b1;
    #1;

    // T6 PC wrap and counter saturation
    goto("t6.goto", 32'hFFFF_FFFC);
    seq_step("t6.wrap", 32'hCAFE_F00D);
    check("t6.pc0", imem_addr, 32'h0);
    check("t6.pc4", if_id_pc4, 32'h0);
    for (int i = 0; i < 20; i++) step("t6.stall", 1, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    check("t6.sat", 32'(stall_cnt), 32'd15);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0), $urandom(),
           ($urandom_range(0, 5) == 0), $urandom(), $urandom(),
           ($urandom_range(0, 5) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
